// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers to fabric logic.
// Independent write (collect/exec/resp) and read (addr/data) FSMs; all outputs registered.
module axi_lite_reg_slave #(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [31:0]                awaddr,
   input  logic [2:0]                 awprot,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [31:0]                wdata,
   input  logic [3:0]                 wstrb,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [1:0]                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   input  logic [31:0]                araddr,
   input  logic [2:0]                 arprot,
   input  logic                       arvalid,
   output logic                       arready,
   output logic [31:0]                rdata,
   output logic [1:0]                 rresp,
   output logic                       rvalid,
   input  logic                       rready,
   output logic [32*NUM_REGS-1:0]     reg_out,
   output logic [NUM_REGS-1:0]        reg_wr_pulse
);

   localparam int unsigned IDX_W  = 30;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_RESP} wstate_e;
   typedef enum logic       {R_ADDR, R_DATA}            rstate_e;

   wstate_e                 wstate_q, wstate_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [IDX_W-1:0]        widx_q, widx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [NUM_REGS-1:0]     pulse_q, pulse_d;
   logic [31:0]             regs_q [NUM_REGS];
   logic [31:0]             regs_d [NUM_REGS];

   rstate_e                 rstate_q, rstate_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic                    wr_in_range;
   logic                    rd_in_range;
   logic                    unused_inputs;

   assign wr_in_range   = widx_q < IDX_W'(NUM_REGS);
   assign rd_in_range   = araddr[31:2] < IDX_W'(NUM_REGS);
   assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

   // Write path: gather AW and W in any order, commit for one cycle, then hold the response
   always_comb begin
      wstate_d  = wstate_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      widx_d    = widx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      pulse_d   = '0;
      regs_d    = regs_q;
      unique case (wstate_q)
         W_COLLECT: begin
            if (awvalid && awready_q) begin
               aw_done_d = 1'b1;
               widx_d    = awaddr[31:2];
            end
            if (wvalid && wready_q) begin
               w_done_d = 1'b1;
               wdata_d  = wdata;
               wstrb_d  = wstrb;
            end
            if (aw_done_d && w_done_d) begin
               wstate_d  = W_EXEC;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
            end else begin
               awready_d = !aw_done_d;
               wready_d  = !w_done_d;
            end
         end
         W_EXEC: begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? OKAY : SLVERR;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
               if (wr_in_range && (widx_q == IDX_W'(k))) begin
                  pulse_d[k] = 1'b1;
                  for (int b = 0; b < 4; b++) begin
                     if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                  end
               end
            end
            wstate_d = W_RESP;
         end
         W_RESP: begin
            if (bready && bvalid_q) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               wstate_d  = W_COLLECT;
            end
         end
         default: wstate_d = W_COLLECT;
      endcase
   end

   // Read path: registers are sampled at the AR edge, so a same-edge write returns the old value
   always_comb begin
      rstate_d  = rstate_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (rstate_q)
         R_ADDR: begin
            if (arvalid && arready_q) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rresp_d   = rd_in_range ? OKAY : SLVERR;
               rdata_d   = '0;
               for (int unsigned k = 0; k < NUM_REGS; k++) begin
                  if (rd_in_range && (araddr[31:2] == IDX_W'(k))) rdata_d = regs_q[k];
               end
               rstate_d  = R_DATA;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (rready && rvalid_q) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               rstate_d  = R_ADDR;
            end
         end
         default: rstate_d = R_ADDR;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wstate_q  <= W_COLLECT;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         widx_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         pulse_q   <= '0;
      end else begin
         wstate_q  <= wstate_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         widx_q    <= widx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         pulse_q   <= pulse_d;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VALUE;
      end else begin
         for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rstate_q  <= R_ADDR;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         rstate_q  <= rstate_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[32*g +: 32] = regs_q[g];
   end

   assign awready      = awready_q;
   assign wready       = wready_q;
   assign bvalid       = bvalid_q;
   assign bresp        = bresp_q;
   assign arready      = arready_q;
   assign rvalid       = rvalid_q;
   assign rdata        = rdata_q;
   assign rresp        = rresp_q;
   assign reg_wr_pulse = pulse_q;

endmodule
